// File: rtl/fpu_mul_iterative.sv
// Iterative IEEE-754-style multiplier, default FP16.
// Shift-add significand loop, RNE rounding, flush-to-zero, start/busy/done.
module fpu_mul_iterative #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);

  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] CLAST = CW'(MAN_W + 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [SW-1:0]        man_q, man_d;
  logic                 g_q, g_d, r_q, r_d, s_q, s_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [W-1:0]         res_q, res_d;
  logic [3:0]           flg_q, flg_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_inf, a_nan, a_snan, a_zero;
  logic             b_inf, b_nan, b_snan, b_zero;
  logic             sgn;
  logic [SW-1:0]    siga, sigb;

  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  assign sgn = a_q[W-1] ^ b_q[W-1];
  assign siga = {1'b1, fa};
  assign sigb = {1'b1, fb};

  // Zero exponent covers subnormals too: they flush to signed zero.
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = &ea & ~|fa;
  assign b_inf  = &eb & ~|fb;
  assign a_nan  = &ea & |fa;
  assign b_nan  = &eb & |fb;
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];

  logic                 rup, carry;
  logic [SW:0]          man_r;
  logic signed [XW-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;

  assign rup    = g_q & (r_q | s_q | man_q[0]);
  assign man_r  = {1'b0, man_q} + {{SW{1'b0}}, rup};
  assign carry  = man_r[SW];
  assign exp_r  = exp_q + {{(XW-1){1'b0}}, carry};
  assign frac_r = carry ? man_r[MAN_W:1] : man_r[MAN_W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    man_d   = man_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        acc_d   = '0;
        cnt_d   = '0;
        exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        flg_d   = 4'b0000;
        if (a_nan | b_nan) begin
          res_d = QNAN;
          flg_d = {a_snan | b_snan, 3'b000};
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
          res_d = QNAN;
          flg_d = 4'b1000;
        end else if (a_inf | b_inf) begin
          res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
          res_d = {sgn, {(W-1){1'b0}}};
        end else begin
          state_d = S_MUL;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          flg_d   = flg_q;
        end
      end
      S_MUL: begin
        if (cnt_q == CLAST) begin
          state_d = S_NORM;
        end else begin
          if (sigb[cnt_q]) acc_d = acc_q + (PW'(siga) << cnt_q);
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NORM: begin
        state_d = S_ROUND;
        if (acc_q[PW-1]) begin
          man_d = acc_q[PW-1 -: SW];
          g_d   = acc_q[PW-1-SW];
          r_d   = acc_q[PW-2-SW];
          s_d   = |acc_q[PW-3-SW:0];
          exp_d = exp_q + XW'(1);
        end else begin
          man_d = acc_q[PW-2 -: SW];
          g_d   = acc_q[PW-2-SW];
          r_d   = acc_q[PW-3-SW];
          s_d   = |acc_q[PW-4-SW:0];
        end
      end
      S_ROUND: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (exp_r >= EMAX) begin
          res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d = 4'b0101;
        end else if (exp_r[XW-1] || exp_r == '0) begin
          res_d = {sgn, {(W-1){1'b0}}};
          flg_d = 4'b0011;
        end else begin
          res_d = {sgn, exp_r[EXP_W-1:0], frac_r};
          flg_d = {3'b000, g_q | r_q | s_q};
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      man_q   <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign flags  = flg_q;

endmodule
